alu_seq: RTL

Parametrised, registered successor of the 4-bit combinational ALU. It takes operands A and B of width W with a 3-bit opcode through a valid/ready input handshake. Single-cycle operations (add, sub, compare, and/or/xor) complete in one cycle; unsigned multiply runs as a multi-cycle shift-add. Results and flags are held in an output register with a valid/ready handshake, so the block sits between an operand source (register file or test sequencer) and a result consumer that may apply backpressure.

---
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one edge; unsigned MUL is a W-cycle shift-add.
module alu_seq #(
  parameter int unsigned W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  res,
  output logic            carry,
  output logic            gt,
  output logic            eq,
  output logic            lt,
  output logic            zero,
  output logic            err
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   res_q, res_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            carry_q, carry_d;
  logic            gt_q, gt_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic            accept;
  logic [W:0]      sum;
  logic [W-1:0]    diff;
  logic [RW-1:0]   acc_add;
  logic [RW-1:0]   sc_res;

  // Ready is free in IDLE; in DONE it is only free if the held result leaves now.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state, datapath and output-register loads.
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    carry_d     = carry_q;
    gt_d        = gt_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    zero_d      = zero_q;
    err_d       = err_q;
    sc_res      = '0;

    sum     = {1'b0, a} + {1'b0, b};
    diff    = a - b;
    acc_add = acc_q + (mplier_q[0] ? mcand_q : RW'(0));

    case (state_q)
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          res_d       = acc_add;
          carry_d     = 1'b0;
          gt_d        = 1'b0;
          eq_d        = 1'b0;
          lt_d        = 1'b0;
          err_d       = 1'b0;
          zero_d      = (acc_add == RW'(0));
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (op == OP_MUL) begin
        state_d     = BUSY;
        out_valid_d = 1'b0;
        mcand_d     = RW'(a);
        mplier_d    = b;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        carry_d     = 1'b0;
        gt_d        = 1'b0;
        eq_d        = 1'b0;
        lt_d        = 1'b0;
        err_d       = 1'b0;
        case (op)
          OP_ADD: begin
            sc_res  = RW'(sum[W-1:0]);
            carry_d = sum[W];
          end
          OP_SUB: begin
            sc_res  = RW'(diff);
            carry_d = (a < b);
          end
          OP_CMP: begin
            gt_d = (a > b);
            eq_d = (a == b);
            lt_d = (a < b);
          end
          OP_AND:  sc_res = RW'(a & b);
          OP_OR:   sc_res = RW'(a | b);
          OP_XOR:  sc_res = RW'(a ^ b);
          default: err_d  = 1'b1;
        endcase
        res_d  = sc_res;
        zero_d = (sc_res == RW'(0));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      res_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign carry     = carry_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule
